mont_pre: RTL and testbench
===========================

Name: mont_pre

Overview:
- Montgomery-domain pre-processing stage. Computes V = (A x B) mod N by iterated double-and-add with per-step reduction.
- Typical use: A = 2^W, converting an operand Y into Y*2^W mod N before it enters the downstream Montgomery multiplier.
- Multi-cycle, fixed-latency block with a start/finish handshake, so the RSA controller can sequence it ahead of the multiplier.

Parameters:
- W, 256, operand width in bits (N, B, V_o). A is W+1 bits so that 2^W is representable.

Ports:
- clk_i  input  1  clock; all state updates on rising edge.
- rst_i  input  1  synchronous, active-high reset.
- start_i  input  1  request. Sampled only in IDLE; one-cycle pulse or level both accepted.
- N_i  input  W  modulus. Must satisfy N > 1. Sampled on accepted start.
- A_i  input  W+1  multiplier (e.g. 2^W). Sampled on accepted start.
- B_i  input  W  multiplicand. Must satisfy B < N. Sampled on accepted start.
- V_o  output  W  result (A*B) mod N. Registered; holds until the next result is written.
- finish_o  output  1  one-cycle pulse, coincident with the cycle in which V_o first shows the new result.
- busy_o  output  1  high in CALC and DONE.

Behaviour:
- Reset (rst_i=1 at a clock edge, any state): state=IDLE, V_o=0, finish_o=0, busy_o=0; internal m, t, counter cleared. Reset has priority over every other input, including mid-operation; an aborted operation produces no finish_o.
- States:
  - IDLE: on start_i=1, latch N, A, B; set m=0, t=B, i=0; go to CALC. start_i=0 stays in IDLE.
  - CALC: one iteration per cycle, i = 0..W (W+1 iterations):
    - if A[i]=1: m' = m + t, then m' = m' - N if m' >= N; else m' = m.
    - t' = 2t, then t' = t' - N if t' >= N.
    - i' = i + 1.
    - The iteration with i = W writes V_o = m' and goes to DONE.
  - DONE: finish_o=1 for exactly this cycle; next edge goes to IDLE.
- Width rule: sums m+t and 2t are computed at W+1 bits, with no truncation before the compare. Invariants m < N and t < N hold after every iteration.
- Latency: if start is accepted at edge k, iterations occur at edges k+1 .. k+W+1. V_o updates and finish_o rises at edge k+W+1; finish_o falls and busy_o falls at edge k+W+2.
- Fixed latency: there is no early exit on zero high bits of A.
- start_i in CALC or DONE is ignored; it is not queued.
- start_i held high through DONE: the block returns to IDLE for one cycle, then re-accepts at the following edge.
- Inputs may change freely after the accepted-start edge.
- V_o is never altered except by reset or by the completion of an operation.
- Out-of-range inputs (B >= N, N <= 1): result is undefined; the block must not hang and still completes in W+1 iterations.

Test Plan:
1. W=8, N=23, A=256, B=5 -> V_o=15; finish_o is a single pulse 9 edges after the start edge; busy_o is high for 10 cycles.
2. W=8, N=23, A=256, B=22 -> V_o=20. W=8, N=23, A=511, B=5 -> V_o=2 (exercises every add and reduction).
3. W=8, N=23, A=0, B=7 -> V_o=0 with identical latency. A=1, B=22 -> V_o=22.
4. W=256, N=2^256-1, A=2^256, B=1 -> V_o=1. N=2^255+1, A=2^256, B=1 -> V_o=2^255-1 (full-width carry path).
5. W=8: start, then pulse start_i again mid-CALC with different operands -> first result (15) is unaffected; no second finish_o until a new start is issued in IDLE.
6. W=8: start, assert rst_i at iteration 4 -> next cycle IDLE, V_o=0, no finish_o. A fresh start then yields the correct result.

Source files
------------

// File: rtl/mont_pre.sv
// mont_pre: computes V = (A * B) mod N by iterated double-and-add with a
// modular reduction after every step. One iteration per clock, fixed latency
// of W+1 iterations, start/finish handshake.
module mont_pre #(
  parameter int unsigned W = 256
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         start_i,
  input  logic [W-1:0] N_i,
  input  logic [W:0]   A_i,
  input  logic [W-1:0] B_i,
  output logic [W-1:0] V_o,
  output logic         finish_o,
  output logic         busy_o
);

  localparam int unsigned CW = $clog2(W + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   n_q, n_d;
  logic [W:0]     a_q, a_d;
  logic [W-1:0]   m_q, m_d;
  logic [W-1:0]   t_q, t_d;
  logic [W-1:0]   v_q, v_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           finish_q, finish_d;
  logic           busy_q, busy_d;

  // One double-and-add step; sums kept at W+1 bits so the compare sees the carry
  logic [W:0]     n_ext;
  logic [W:0]     m_sum;
  logic [W:0]     t_dbl;
  logic [W-1:0]   m_step;
  logic [W-1:0]   t_step;

  // Iteration datapath: conditional add of t into m, doubling of t, both reduced mod N
  always_comb begin
    n_ext  = {1'b0, n_q};
    m_sum  = {1'b0, m_q} + {1'b0, t_q};
    t_dbl  = {t_q, 1'b0};
    m_step = m_q;
    if (a_q[0]) begin
      if (m_sum >= n_ext) begin
        m_step = W'(m_sum - n_ext);
      end else begin
        m_step = W'(m_sum);
      end
    end
    if (t_dbl >= n_ext) begin
      t_step = W'(t_dbl - n_ext);
    end else begin
      t_step = W'(t_dbl);
    end
  end

  // Next-state and next-register logic; A is shifted right so bit i is always at a_q[0]
  always_comb begin
    state_d  = state_q;
    n_d      = n_q;
    a_d      = a_q;
    m_d      = m_q;
    t_d      = t_q;
    v_d      = v_q;
    cnt_d    = cnt_q;
    finish_d = 1'b0;
    busy_d   = busy_q;
    unique case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (start_i) begin
          n_d     = N_i;
          a_d     = A_i;
          m_d     = '0;
          t_d     = B_i;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = CALC;
        end
      end
      CALC: begin
        m_d   = m_step;
        t_d   = t_step;
        a_d   = a_q >> 1;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(W)) begin
          v_d      = m_step;
          finish_d = 1'b1;
          state_d  = DONE;
        end
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset taking priority
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      n_q      <= '0;
      a_q      <= '0;
      m_q      <= '0;
      t_q      <= '0;
      v_q      <= '0;
      cnt_q    <= '0;
      finish_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      n_q      <= n_d;
      a_q      <= a_d;
      m_q      <= m_d;
      t_q      <= t_d;
      v_q      <= v_d;
      cnt_q    <= cnt_d;
      finish_q <= finish_d;
      busy_q   <= busy_d;
    end
  end

  assign V_o      = v_q;
  assign finish_o = finish_q;
  assign busy_o   = busy_q;

endmodule

// File: tb/tb_mont_pre.sv
// tb_mont_pre: directed, table-driven checks of mont_pre at W=8 plus two
// full-width W=256 cases, with hand sequences for abort and ignored starts.
module tb_mont_pre;

  logic         clk;
  logic         rst;

  logic         start8;
  logic [7:0]   n8;
  logic [8:0]   a8;
  logic [7:0]   b8;
  logic [7:0]   v8;
  logic         finish8;
  logic         busy8;

  logic         start256;
  logic [255:0] n256;
  logic [256:0] a256;
  logic [255:0] b256;
  logic [255:0] v256;
  logic         finish256;
  logic         busy256;

  int checks = 0;
  int errors = 0;

  mont_pre #(.W(8)) u_dut8 (
    .clk_i    (clk),
    .rst_i    (rst),
    .start_i  (start8),
    .N_i      (n8),
    .A_i      (a8),
    .B_i      (b8),
    .V_o      (v8),
    .finish_o (finish8),
    .busy_o   (busy8)
  );

  mont_pre #(.W(256)) u_dut256 (
    .clk_i    (clk),
    .rst_i    (rst),
    .start_i  (start256),
    .N_i      (n256),
    .A_i      (a256),
    .B_i      (b256),
    .V_o      (v256),
    .finish_o (finish256),
    .busy_o   (busy256)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] n;
    logic [8:0] a;
    logic [7:0] b;
    logic [7:0] v;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Full W=8 transaction: latency, busy/V stability during CALC, result, release
  task automatic run8(input logic [7:0] n, input logic [8:0] a, input logic [7:0] b,
                      input logic [7:0] exp);
    int lat;
    bit got;
    bit stable;
    logic [7:0] v_prev;
    @(negedge clk);
    n8 = n; a8 = a; b8 = b; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    n8 = 8'($urandom); a8 = 9'($urandom); b8 = 8'($urandom);
    chk("busy_after_start", 256'(busy8), 256'(1));
    v_prev = v8;
    lat = 0; got = 1'b0; stable = 1'b1;
    for (int c = 0; c < 20 && !got; c++) begin
      @(posedge clk); #1;
      lat++;
      if (finish8) got = 1'b1;
      else if (!busy8 || v8 !== v_prev) stable = 1'b0;
    end
    chk("latency8", 256'(lat), 256'(9));
    chk("stable_calc8", 256'(stable), 256'(1));
    chk("result8", 256'(v8), 256'(exp));
    chk("busy_at_finish8", 256'(busy8), 256'(1));
    @(posedge clk); #1;
    chk("release8", 256'({finish8, busy8}), 256'(0));
  endtask

  task automatic run256(input logic [255:0] n, input logic [256:0] a, input logic [255:0] b,
                        input logic [255:0] exp);
    int lat;
    bit got;
    @(negedge clk);
    n256 = n; a256 = a; b256 = b; start256 = 1'b1;
    @(posedge clk); #1;
    start256 = 1'b0;
    n256 = '0; a256 = '0; b256 = '0;
    lat = 0; got = 1'b0;
    for (int c = 0; c < 300 && !got; c++) begin
      @(posedge clk); #1;
      lat++;
      if (finish256) got = 1'b1;
    end
    chk("latency256", 256'(lat), 256'(257));
    chk("result256", v256, exp);
    @(posedge clk); #1;
    chk("release256", 256'({finish256, busy256}), 256'(0));
  endtask

  initial begin
    int lat;
    int nfin;
    bit got;
    logic [255:0] big_n;
    logic [256:0] big_a;
    logic [255:0] big_e;

    vecs[0] = '{n: 8'd23,  a: 9'd256, b: 8'd5,   v: 8'd15};
    vecs[1] = '{n: 8'd23,  a: 9'd256, b: 8'd22,  v: 8'd20};
    vecs[2] = '{n: 8'd23,  a: 9'd511, b: 8'd5,   v: 8'd2};
    vecs[3] = '{n: 8'd23,  a: 9'd0,   b: 8'd7,   v: 8'd0};
    vecs[4] = '{n: 8'd23,  a: 9'd1,   b: 8'd22,  v: 8'd22};
    vecs[5] = '{n: 8'd23,  a: 9'd100, b: 8'd17,  v: 8'd21};
    vecs[6] = '{n: 8'd255, a: 9'd256, b: 8'd254, v: 8'd254};
    vecs[7] = '{n: 8'd2,   a: 9'd511, b: 8'd1,   v: 8'd1};

    rst = 1'b1;
    start8 = 1'b0; n8 = '0; a8 = '0; b8 = '0;
    start256 = 1'b0; n256 = '0; a256 = '0; b256 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_v8", 256'(v8), 256'(0));
    chk("reset_flags8", 256'({finish8, busy8}), 256'(0));
    chk("reset_v256", v256, 256'(0));
    chk("reset_flags256", 256'({finish256, busy256}), 256'(0));
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      run8(vecs[i].n, vecs[i].a, vecs[i].b, vecs[i].v);
    end

    // start pulsed mid-CALC with other operands must be ignored
    @(negedge clk);
    n8 = 8'd23; a8 = 9'd256; b8 = 8'd5; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    lat = 0; got = 1'b0;
    for (int c = 1; c <= 20 && !got; c++) begin
      @(posedge clk); #1;
      lat = c;
      if (finish8) got = 1'b1;
      if (c == 3) begin
        start8 = 1'b1; n8 = 8'd50; a8 = 9'd3; b8 = 8'd9;
      end
      if (c == 4) start8 = 1'b0;
    end
    chk("ignored_start_latency", 256'(lat), 256'(9));
    chk("ignored_start_result", 256'(v8), 256'(15));
    nfin = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (finish8 || busy8) nfin++;
    end
    chk("no_second_finish", 256'(nfin), 256'(0));
    chk("result_held", 256'(v8), 256'(15));

    // reset asserted at iteration 4 aborts without a finish
    @(negedge clk);
    n8 = 8'd23; a8 = 9'd511; b8 = 8'd5; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("abort_v", 256'(v8), 256'(0));
    chk("abort_flags", 256'({finish8, busy8}), 256'(0));
    rst = 1'b0;
    nfin = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (finish8 || busy8) nfin++;
    end
    chk("abort_no_finish", 256'(nfin), 256'(0));
    run8(8'd23, 9'd256, 8'd5, 8'd15);

    // start held high through DONE: one IDLE cycle, then re-accept
    @(negedge clk);
    n8 = 8'd23; a8 = 9'd256; b8 = 8'd22; start8 = 1'b1;
    @(posedge clk); #1;
    got = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(posedge clk); #1;
      if (finish8) got = 1'b1;
    end
    chk("held_first_finish", 256'(got), 256'(1));
    chk("held_first_result", 256'(v8), 256'(20));
    @(posedge clk); #1;
    chk("held_idle_gap", 256'(busy8), 256'(0));
    @(posedge clk); #1;
    chk("held_reaccept", 256'(busy8), 256'(1));
    start8 = 1'b0;
    lat = 1; got = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(posedge clk); #1;
      lat++;
      if (finish8) got = 1'b1;
    end
    chk("held_second_latency", 256'(lat), 256'(10));
    chk("held_second_result", 256'(v8), 256'(20));

    // full-width cases exercising the 2t carry bit
    big_n = '1;
    big_a = 257'(1) << 256;
    run256(big_n, big_a, 256'(1), 256'(1));
    big_n = (256'(1) << 255) + 256'(1);
    big_e = (256'(1) << 255) - 256'(1);
    run256(big_n, big_a, 256'(1), big_e);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
